// File: rtl/pulse_pair_collector_if.sv
// Bundle between the sweep decoder / serial transmitter and the pulse pair collector.
// The master side drives pulses and acks; the slave side presents the captured frame.
interface pulse_pair_collector_if;
    logic        pulse_valid;
    logic [16:0] pulse_offset;
    logic [16:0] pulse_poly;
    logic        reset_pulse_identifier;
    logic [16:0] pulse_id_0;
    logic [16:0] pulse_id_1;
    logic [16:0] polynomial;
    logic        data_availible;
    logic [7:0]  dropped_count;

    modport master (
        output pulse_valid, pulse_offset, pulse_poly, reset_pulse_identifier,
        input  pulse_id_0, pulse_id_1, polynomial, data_availible, dropped_count
    );

    modport slave (
        input  pulse_valid, pulse_offset, pulse_poly, reset_pulse_identifier,
        output pulse_id_0, pulse_id_1, polynomial, data_availible, dropped_count
    );
endinterface

// File: rtl/pulse_pair_collector.sv
// Pairs two decoded pulses sharing a polynomial within a timeout window into a frame,
// and holds that frame until the transmitter acknowledges it.
module pulse_pair_collector #(
    parameter int TIMEOUT_CYCLES = 12000,
    parameter int TMR_W          = 14
) (
    input  logic                   clk_12MHz,
    input  logic                   rstn,
    pulse_pair_collector_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [16:0]      first_off_q;
    logic [16:0]      first_poly_q;
    logic [TMR_W-1:0] timer_q;
    logic [16:0]      id0_q;
    logic [16:0]      id1_q;
    logic [16:0]      poly_q;
    logic             avail_q;
    logic [7:0]       drop_q;

    logic             poly_match_d;
    assign poly_match_d = (bus.pulse_poly == first_poly_q);

    always_ff @(posedge clk_12MHz or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            first_off_q  <= '0;
            first_poly_q <= '0;
            timer_q      <= '0;
            id0_q        <= '0;
            id1_q        <= '0;
            poly_q       <= '0;
            avail_q      <= 1'b0;
            drop_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.pulse_valid) begin
                        first_off_q  <= bus.pulse_offset;
                        first_poly_q <= bus.pulse_poly;
                        timer_q      <= '0;
                        state_q      <= WAIT2;
                    end
                end

                WAIT2: begin
                    // A pulse on the timeout cycle itself still counts as in-window.
                    if (bus.pulse_valid) begin
                        if (poly_match_d) begin
                            id0_q   <= first_off_q;
                            id1_q   <= bus.pulse_offset;
                            poly_q  <= first_poly_q;
                            avail_q <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            first_off_q  <= bus.pulse_offset;
                            first_poly_q <= bus.pulse_poly;
                            timer_q      <= '0;
                        end
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                HOLD: begin
                    // Frame registers stay put after the ack; the transmitter samples them on that edge.
                    if (bus.reset_pulse_identifier) begin
                        avail_q <= 1'b0;
                        if (bus.pulse_valid) begin
                            first_off_q  <= bus.pulse_offset;
                            first_poly_q <= bus.pulse_poly;
                            timer_q      <= '0;
                            state_q      <= WAIT2;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (bus.pulse_valid && (drop_q != 8'hFF)) begin
                        drop_q <= drop_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    avail_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse_id_0     = id0_q;
    assign bus.pulse_id_1     = id1_q;
    assign bus.polynomial     = poly_q;
    assign bus.data_availible = avail_q;
    assign bus.dropped_count  = drop_q;

endmodule
